// File: rtl/rr_select_arbiter4.sv
// Round-robin arbiter driving the 2-bit select of a downstream 4:1 mux.
// Holds the grant for up to MAX_BURST accepted beats and acks each accepted beat.
module rr_select_arbiter4 #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] ack,
  output logic [1:0] select,
  output logic       valid,
  input  logic       ready
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

  state_t     state_reg, state_next;
  logic [1:0] select_reg, select_next;
  logic [1:0] rr_ptr_reg, rr_ptr_next;
  logic [7:0] beat_cnt_reg, beat_cnt_next;

  logic [1:0] arb_base;
  logic [1:0] arb_idx;
  logic [1:0] winner;
  logic       any_req;
  logic       accept;
  logic       burst_end;

  // At end of burst the scan starts just past the current owner; from IDLE it uses rr_ptr.
  assign arb_base = (state_reg == GRANT) ? select_reg + 2'd1 : rr_ptr_reg;
  assign any_req  = |req;

  // Scan from the farthest offset down so the nearest requesting index wins last.
  always_comb begin
    winner  = arb_base;
    arb_idx = arb_base;
    for (int k = 3; k >= 0; k--) begin
      arb_idx = arb_base + 2'(k);
      if (req[arb_idx]) winner = arb_idx;
    end
  end

  // Outputs are forced low during reset so no beat is acknowledged in that cycle.
  assign valid  = !rst && (state_reg == GRANT) && req[select_reg];
  assign accept = valid && ready;
  assign select = select_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ack
      assign ack[gi] = accept && (select_reg == 2'(gi));
    end
  endgenerate

  assign burst_end = (state_reg == GRANT) &&
                     (!req[select_reg] || (accept && (beat_cnt_reg + 8'd1 == BURST_LIMIT)));

  always_comb begin
    state_next    = state_reg;
    select_next   = select_reg;
    rr_ptr_next   = rr_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          select_next   = winner;
          beat_cnt_next = 8'd0;
          state_next    = GRANT;
        end
      end
      GRANT: begin
        if (burst_end) begin
          rr_ptr_next   = select_reg + 2'd1;
          beat_cnt_next = 8'd0;
          if (any_req) begin
            select_next = winner;
          end else begin
            state_next  = IDLE;
          end
        end else if (accept) begin
          beat_cnt_next = beat_cnt_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      select_reg   <= 2'd0;
      rr_ptr_reg   <= 2'd0;
      beat_cnt_reg <= 8'd0;
    end else begin
      state_reg    <= state_next;
      select_reg   <= select_next;
      rr_ptr_reg   <= rr_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

endmodule

// File: doc/rr_select_arbiter4.md
Name: rr_select_arbiter4

Overview:
- Sequential round-robin arbiter that drives the 2-bit select of the downstream 4:1 N-bit mux (mux4).
- Four requesters compete for one shared output channel. The block picks a winner, holds select stable for the duration of a burst, and performs the valid/ready handshake with the consumer.
- It returns a per-requester ack on each accepted beat.
- Data itself flows through mux4; this block owns only select and control.

Parameters:
- MAX_BURST, 4, maximum accepted beats per grant before forced rotation (legal range 1..255).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  4  req[i] high = requester i has a beat pending; must stay high until ack[i]
- ack  output 4  one-hot; ack[i] high for exactly the cycle in which requester i's beat is accepted
- select  output 2  index of granted requester; connects to mux4 select
- valid  output 1  mux4 out carries a valid beat from requester select
- ready  input  1  downstream consumer accepts the beat when valid && ready

Behaviour:
- Reset is synchronous, active-high, and wins over all other events, including mid-burst. After the reset edge:
  - state=IDLE, select=0, rr_ptr=0, beat_cnt=0
  - valid=0, ack=0
- State: IDLE, GRANT. Registered: select (2b), rr_ptr (2b), beat_cnt (8b).
- Arbitration function: scan req starting at index rr_ptr, in order rr_ptr, rr_ptr+1, ..., wrapping mod 4. The first index with req high wins.
- IDLE:
  - If any req is high, register select=winner, beat_cnt=0, go to GRANT.
  - Otherwise stay in IDLE.
  - Latency: req rising in cycle t gives valid=1 in cycle t+1.
- valid = (state==GRANT) && req[select], combinational from registered state.
- ack = onehot(select) when valid && ready, else 0. Combinational.
- GRANT, beat accepted (valid && ready):
  - The burst ends if beat_cnt+1 == MAX_BURST.
  - Otherwise beat_cnt increments and the state stays in GRANT with the same select. The requester may present its next beat the following cycle.
- GRANT, valid && !ready (backpressure): hold select, beat_cnt and state unchanged. valid stays 1 while req is held.
- GRANT, req[select] low: treated as end of burst. No transfer, no ack.
- End of burst, in the same cycle:
  - rr_ptr <= select+1 (mod 4, 3 wraps to 0).
  - Re-arbitrate starting from select+1 using the current req vector.
  - If there is a winner: register the new select, beat_cnt=0, stay in GRANT. There is no bubble cycle.
  - If no req is high: go to IDLE.
  - The just-served requester can win again only if no other req is high.
- select changes only at reset, on the IDLE→GRANT transition, or at end of burst. It never changes while valid && !ready.
- ack is at most one-hot. It is never asserted in IDLE or during reset.
- MAX_BURST=1 gives pure per-beat round robin.

Test Plan:
- Reset and idle:
  - Stimulus: rst held 2 cycles with req=4'b1111, then released.
  - Required: select=0, valid=0, ack=0 during reset. Cycle after release: select=0, valid=1.
- Single requester, burst limit:
  - Stimulus: req=4'b0100 held, ready=1, MAX_BURST=4.
  - Required: select=2. ack=4'b0100 on 4 consecutive cycles, then re-grant of 2 with no other requesters, for continuous acks.
- Round robin with wrap:
  - Stimulus: req=4'b1111 held, ready=1, MAX_BURST=1.
  - Required: select sequence 0,1,2,3,0,1 with no bubbles. ack one-hot matches select each cycle.
- Backpressure:
  - Stimulus: req=4'b0010, ready=0 for 3 cycles, then 1.
  - Required: valid=1 and select=1 constant, ack=0 during stall. ack=4'b0010 on the first ready cycle. beat_cnt unchanged across the stall.
- Early drop and rotation:
  - Stimulus: grant to 3 (req=4'b1001, rr_ptr=3), then req[3] drops after 1 beat with req[0] high.
  - Required: next cycle select=0, valid=1. rr_ptr=0 after the handoff.
- Reset mid-burst:
  - Stimulus: rst asserted while select=2, beat_cnt=2, valid=1, ready=1.
  - Required: ack=0 in the reset cycle. Next cycle select=0, valid=0, and the next grant starts from index 0.
